pipe_retire_monitor: RTL and testbench
======================================

// Module: pipe_retire_monitor
// PURPOSE
//   Synthesizable, parametrised monitor for an in-order N-stage RV32I pipeline.
//   Samples the per-stage PCs and valid bits and counts cycles, retirements and bubbles.
//   Detects end-of-program (WB PC >= END_PC) and a no-retire watchdog timeout.
//   Buffers retired PCs in a ready/valid trace FIFO.
//   Sits beside the pipeline top; replaces ad-hoc bench-side $finish checks.
// PARAMETERS
//   XLEN         32   PC width
//   NSTAGE       5    pipeline stages; stage 0 = IF, stage NSTAGE-1 = WB
//   END_PC       40   retiring PC >= this value (unsigned compare) ends the run
//   WDOG_CYCLES  64   number of consecutive RUN cycles without a retire that raises timeout (>=2)
//   TRACE_DEPTH  8    trace FIFO entries, power of 2, >=2
//   CNT_W        32   width of every statistics counter
// PORTS
//   clk          in   1              clock, rising edge
//   rst          in   1              asynchronous, active-high reset
//   en           in   1              monitor enable
//   stage_pc     in   NSTAGE*XLEN    packed stage PCs, stage i at [i*XLEN +: XLEN]
//   stage_vld    in   NSTAGE         stage holds a real instruction (0 = bubble)
//   trace_rdy    in   1              consumer accepts trace entry
//   trace_vld    out  1              trace entry available
//   trace_pc     out  XLEN           oldest retired PC in FIFO
//   trace_ovf    out  1              sticky: a retire was dropped because the FIFO was full
//   cycle_cnt    out  CNT_W          RUN cycles
//   retired_cnt  out  CNT_W          retirements while in RUN
//   bubble_cnt   out  CNT_W          RUN cycles with no retirement
//   state        out  2              FSM state
//   done         out  1              state == DONE
//   timeout      out  1              state == TIMEOUT
// BEHAVIOUR
//   - rst (async): state=IDLE; all counters=0; FIFO empty; trace_vld=0; trace_pc=0;
//     trace_ovf=0; done=0; timeout=0; watchdog=0.
//   - retire = stage_vld[NSTAGE-1]; wb_pc = stage_pc[(NSTAGE-1)*XLEN +: XLEN].
//   - FSM states: IDLE=0, RUN=1, DONE=2, TIMEOUT=3.
//     IDLE: go to RUN when en=1. Nothing is counted in the cycle that en is first sampled.
//     RUN with en=0: go to IDLE. Counters and FIFO hold; the watchdog clears.
//     RUN with retire && wb_pc>=END_PC: go to DONE.
//     RUN otherwise, when the watchdog is WDOG_CYCLES-1 and there is no retire: go to TIMEOUT.
//     The done check has priority over the timeout check.
//     DONE and TIMEOUT are sticky until rst. Counters freeze; no further trace pushes.
//   - In RUN, every cycle: cycle_cnt+1.
//     On retire: retired_cnt+1, watchdog=0, push wb_pc. The terminating retire is also counted and pushed.
//     With no retire: bubble_cnt+1, watchdog+1.
//     Every counter saturates at all-ones; it never wraps.
//   - All outputs are registered. done/timeout assert the cycle after the triggering edge.
//   - FIFO: push on retire in RUN.
//     Pop when trace_vld && trace_rdy; pops are allowed in every state.
//     trace_vld = (count!=0). trace_pc = mem[rd_ptr].
//     Full with push and pop in the same cycle: both occur, no overflow.
//     Full with push and no pop: the entry is dropped and trace_ovf=1 (sticky).
//     Empty with push and pop in the same cycle: the pop is ignored (trace_vld=0) and the push is stored.
//     Pointers are log2(TRACE_DEPTH) bits and wrap naturally. count is log2(TRACE_DEPTH)+1 bits.
//   - rst mid-run: immediate return to IDLE. The FIFO contents are discarded.
// STRUCTURE
//   - Shared package pipe_mon_pkg holds the state encodings MON_IDLE/RUN/DONE/TIMEOUT and the 2-bit state type.
//   - One sub-module, mon_trace_fifo (params W, DEPTH). It has:
//     push/pop/din ports; dout/empty/full/ovf ports; clk/rst with the same reset style.
//   - Top level holds the FSM, the watchdog and the three saturating counters.
// TESTING
//   1 No-hazard stream: PCs 0,4,...,40 enter WB on consecutive cycles, en=1, trace_rdy=1.
//     -> retired_cnt=11, bubble_cnt=0, done=1 one cycle after the PC-40 retire,
//        trace pops 0..40 in order.
//   2 Bubbles: WB valid pattern 1,0,0,1 with PCs 0,-,-,4, END_PC=4.
//     -> bubble_cnt=2, retired_cnt=2, cycle_cnt=4, then done.
//   3 Watchdog: WDOG_CYCLES=8, stage_vld=0 for 8 RUN cycles.
//     -> timeout=1 and state=3; counters frozen at cycle_cnt=8, bubble_cnt=8.
//   4 Overflow: TRACE_DEPTH=4, trace_rdy=0, 5 retires.
//     -> 4 entries held, trace_ovf=1. Then a full FIFO with push+pop in the same cycle
//        -> count stays 4, no further overflow.
//   5 en toggle: en=0 for 3 cycles mid-run.
//     -> state=IDLE, counters hold, watchdog resets; resumes on en=1.
//   6 Async rst asserted mid-cycle during RUN with FIFO at 3 entries.
//     -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_retire_monitor_pkg.sv
// Shared definitions for the pipeline retire monitor: FSM state encoding.
package pipe_mon_pkg;

    localparam int MON_STATE_W = 2;

    typedef enum logic [MON_STATE_W-1:0] {
        MON_IDLE    = 2'd0,
        MON_RUN     = 2'd1,
        MON_DONE    = 2'd2,
        MON_TIMEOUT = 2'd3
    } mon_state_t;

endpackage

// File: rtl/pipe_retire_monitor_if.sv
// Bundle between the pipeline/consumer side (master) and the retire monitor (slave).
interface pipe_retire_monitor_if #(
    parameter int XLEN   = 32,
    parameter int NSTAGE = 5,
    parameter int CNT_W  = 32
);
    logic                     en;
    logic [NSTAGE*XLEN-1:0]   stage_pc;
    logic [NSTAGE-1:0]        stage_vld;
    logic                     trace_rdy;
    logic                     trace_vld;
    logic [XLEN-1:0]          trace_pc;
    logic                     trace_ovf;
    logic [CNT_W-1:0]         cycle_cnt;
    logic [CNT_W-1:0]         retired_cnt;
    logic [CNT_W-1:0]         bubble_cnt;
    logic [1:0]               state;
    logic                     done;
    logic                     timeout;

    modport master (
        output en, stage_pc, stage_vld, trace_rdy,
        input  trace_vld, trace_pc, trace_ovf, cycle_cnt, retired_cnt,
               bubble_cnt, state, done, timeout
    );

    modport slave (
        input  en, stage_pc, stage_vld, trace_rdy,
        output trace_vld, trace_pc, trace_ovf, cycle_cnt, retired_cnt,
               bubble_cnt, state, done, timeout
    );
endinterface

// File: rtl/pipe_retire_monitor_fifo.sv
// Trace FIFO for retired PCs; drops pushes when full (sticky ovf) unless a pop frees a slot.
module mon_trace_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          ovf_r;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    assign empty  = (count_r == {(AW+1){1'b0}});
    assign full   = (count_r == CNT_FULL);
    assign dout   = mem_r[rd_ptr_r];
    assign ovf    = ovf_r;
    // A pop on an empty FIFO is ignored; a full FIFO accepts a push only alongside a pop.
    assign pop_s  = pop && !empty;
    assign push_s = push && (!full || pop_s);
    assign drop_s = push && full && !pop_s;

    // Storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/pipe_retire_monitor.sv
// Retire monitor for an in-order pipeline: run FSM, watchdog, saturating statistics, trace FIFO.
module pipe_retire_monitor
    import pipe_mon_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NSTAGE      = 5,
    parameter int END_PC      = 40,
    parameter int WDOG_CYCLES = 64,
    parameter int TRACE_DEPTH = 8,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_retire_monitor_if.slave  mon
);
    localparam int WW = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WW-1:0]    WDOG_ONE  = WW'(1);
    localparam logic [WW-1:0]    WDOG_LAST = WW'(WDOG_CYCLES - 1);
    localparam logic [XLEN-1:0]  END_PC_V  = XLEN'(END_PC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    mon_state_t       state_r;
    logic [WW-1:0]    wdog_r;
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] retired_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic             done_r;
    logic             timeout_r;
    logic             retire_s;
    logic [XLEN-1:0]  wb_pc_s;
    logic             push_s;
    logic             empty_s;
    logic             full_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign retire_s = mon.stage_vld[NSTAGE-1];
    assign wb_pc_s  = mon.stage_pc[(NSTAGE-1)*XLEN +: XLEN];
    // Only retires observed while actively running are traced, including the terminating one.
    assign push_s   = (state_r == MON_RUN) && mon.en && retire_s;

    // Run-control FSM with watchdog and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= MON_IDLE;
            wdog_r        <= {WW{1'b0}};
            cycle_cnt_r   <= {CNT_W{1'b0}};
            retired_cnt_r <= {CNT_W{1'b0}};
            bubble_cnt_r  <= {CNT_W{1'b0}};
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            case (state_r)
                MON_IDLE: begin
                    if (mon.en) begin
                        state_r <= MON_RUN;
                    end
                end
                MON_RUN: begin
                    if (!mon.en) begin
                        state_r <= MON_IDLE;
                        wdog_r  <= {WW{1'b0}};
                    end else begin
                        cycle_cnt_r <= sat_inc(cycle_cnt_r);
                        if (retire_s) begin
                            retired_cnt_r <= sat_inc(retired_cnt_r);
                            wdog_r        <= {WW{1'b0}};
                            if (wb_pc_s >= END_PC_V) begin
                                state_r <= MON_DONE;
                                done_r  <= 1'b1;
                            end
                        end else begin
                            bubble_cnt_r <= sat_inc(bubble_cnt_r);
                            wdog_r       <= wdog_r + WDOG_ONE;
                            if (wdog_r == WDOG_LAST) begin
                                state_r   <= MON_TIMEOUT;
                                timeout_r <= 1'b1;
                            end
                        end
                    end
                end
                MON_DONE:    state_r <= MON_DONE;
                MON_TIMEOUT: state_r <= MON_TIMEOUT;
                default:     state_r <= MON_IDLE;
            endcase
        end
    end

    mon_trace_fifo #(
        .W     (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (mon.trace_rdy),
        .din   (wb_pc_s),
        .dout  (mon.trace_pc),
        .empty (empty_s),
        .full  (full_s),
        .ovf   (mon.trace_ovf)
    );

    assign mon.trace_vld   = !empty_s;
    assign mon.cycle_cnt   = cycle_cnt_r;
    assign mon.retired_cnt = retired_cnt_r;
    assign mon.bubble_cnt  = bubble_cnt_r;
    assign mon.state       = state_r;
    assign mon.done        = done_r;
    assign mon.timeout     = timeout_r;
endmodule

// File: tb/tb_pipe_retire_monitor.sv
// Directed bench: instance A uses default parameters, instance B uses END_PC=4, WDOG_CYCLES=8, TRACE_DEPTH=4.
module tb_pipe_retire_monitor;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] exp_b [5];

    pipe_retire_monitor_if #(.XLEN(32), .NSTAGE(5), .CNT_W(32)) ifa ();
    pipe_retire_monitor_if #(.XLEN(32), .NSTAGE(5), .CNT_W(32)) ifb ();

    pipe_retire_monitor dut_a (.clk(clk), .rst(rst), .mon(ifa));
    pipe_retire_monitor #(.END_PC(4), .WDOG_CYCLES(8), .TRACE_DEPTH(4)) dut_b (.clk(clk), .rst(rst), .mon(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted trace entry; inputs only change just after posedge so negedge sees the pop values.
    always @(negedge clk) begin
        if (ifa.trace_vld && ifa.trace_rdy) qa.push_back(ifa.trace_pc);
        if (ifb.trace_vld && ifb.trace_rdy) qb.push_back(ifb.trace_pc);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-WB stages carry large valid PCs so that reading the wrong slot would be visible.
    task automatic drv_a(input logic v, input logic [31:0] pc);
        ifa.stage_pc  = {pc, {4{32'hFFFF_FFF0}}};
        ifa.stage_vld = {v, 4'b1111};
    endtask

    task automatic drv_b(input logic v, input logic [31:0] pc);
        ifb.stage_pc  = {pc, {4{32'hFFFF_FFF0}}};
        ifb.stage_vld = {v, 4'b1111};
    endtask

    task automatic do_reset();
        ifa.en = 1'b0; ifa.trace_rdy = 1'b0; drv_a(1'b0, 32'd0);
        ifb.en = 1'b0; ifb.trace_rdy = 1'b0; drv_b(1'b0, 32'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        do_reset();

        // Reset state
        chk("rst_state", ifa.state, 2'd0);
        chk("rst_cycle", ifa.cycle_cnt, 32'd0);
        chk("rst_tvld", ifa.trace_vld, 1'b0);
        chk("rst_done", ifa.done, 1'b0);
        chk("rst_ovf", ifa.trace_ovf, 1'b0);

        // 1: no-hazard stream 0..40
        ifa.en = 1'b1; ifa.trace_rdy = 1'b1;
        tick();
        chk("t1_run", ifa.state, 2'd1);
        chk("t1_first_cycle", ifa.cycle_cnt, 32'd0);
        for (int k = 0; k <= 10; k++) begin
            drv_a(1'b1, 32'(4 * k));
            tick();
            if (k == 9) chk("t1_not_done", ifa.done, 1'b0);
        end
        chk("t1_done", ifa.done, 1'b1);
        chk("t1_state", ifa.state, 2'd2);
        chk("t1_retired", ifa.retired_cnt, 32'd11);
        chk("t1_bubble", ifa.bubble_cnt, 32'd0);
        chk("t1_cycle", ifa.cycle_cnt, 32'd11);
        drv_a(1'b0, 32'd0);
        tick(); tick(); tick();
        chk("t1_pops", qa.size(), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < qa.size()) chk("t1_pc", qa[i], 32'(4 * i));
        end
        chk("t1_frozen", ifa.retired_cnt, 32'd11);

        // 2: bubbles with END_PC=4
        do_reset();
        ifb.en = 1'b1; ifb.trace_rdy = 1'b1;
        tick();
        drv_b(1'b1, 32'd0); tick();
        drv_b(1'b0, 32'd0); tick(); tick();
        chk("t2_not_done", ifb.done, 1'b0);
        drv_b(1'b1, 32'd4); tick();
        chk("t2_done", ifb.done, 1'b1);
        chk("t2_state", ifb.state, 2'd2);
        chk("t2_bubble", ifb.bubble_cnt, 32'd2);
        chk("t2_retired", ifb.retired_cnt, 32'd2);
        chk("t2_cycle", ifb.cycle_cnt, 32'd4);

        // 3: watchdog with WDOG_CYCLES=8
        do_reset();
        ifb.en = 1'b1; ifb.trace_rdy = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("t3_still_run", ifb.state, 2'd1);
        chk("t3_no_to", ifb.timeout, 1'b0);
        tick();
        chk("t3_state", ifb.state, 2'd3);
        chk("t3_timeout", ifb.timeout, 1'b1);
        chk("t3_cycle", ifb.cycle_cnt, 32'd8);
        chk("t3_bubble", ifb.bubble_cnt, 32'd8);
        drv_b(1'b1, 32'd0); tick(); tick();
        chk("t3_frz_cycle", ifb.cycle_cnt, 32'd8);
        chk("t3_frz_ret", ifb.retired_cnt, 32'd0);
        chk("t3_frz_tvld", ifb.trace_vld, 1'b0);

        // 4: overflow with TRACE_DEPTH=4
        do_reset();
        ifb.en = 1'b1; ifb.trace_rdy = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            drv_b(1'b1, 32'(i)); tick();
        end
        chk("t4_no_ovf_yet", ifb.trace_ovf, 1'b0);
        drv_b(1'b1, 32'd0); tick();
        chk("t4_ovf", ifb.trace_ovf, 1'b1);
        chk("t4_tvld", ifb.trace_vld, 1'b1);
        chk("t4_head", ifb.trace_pc, 32'd0);
        chk("t4_retired", ifb.retired_cnt, 32'd5);
        qb.delete();
        ifb.trace_rdy = 1'b1;
        drv_b(1'b1, 32'd2); tick();
        drv_b(1'b0, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        exp_b = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd2};
        chk("t4_pops", qb.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < qb.size()) chk("t4_pc", qb[i], exp_b[i]);
        end
        chk("t4_empty", ifb.trace_vld, 1'b0);

        // 5: en toggle, watchdog cleared
        do_reset();
        ifb.en = 1'b1; ifb.trace_rdy = 1'b1;
        tick();
        drv_b(1'b1, 32'd0); tick();
        drv_b(1'b0, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        ifb.en = 1'b0;
        tick(); tick(); tick();
        chk("t5_idle", ifb.state, 2'd0);
        chk("t5_cycle", ifb.cycle_cnt, 32'd6);
        chk("t5_bubble", ifb.bubble_cnt, 32'd5);
        chk("t5_retired", ifb.retired_cnt, 32'd1);
        ifb.en = 1'b1;
        tick();
        chk("t5_resume", ifb.state, 2'd1);
        chk("t5_cycle_resume", ifb.cycle_cnt, 32'd6);
        for (int i = 0; i < 7; i++) tick();
        chk("t5_wdog_cleared", ifb.state, 2'd1);
        chk("t5_cycle2", ifb.cycle_cnt, 32'd13);
        tick();
        chk("t5_timeout", ifb.state, 2'd3);

        // 6: async reset mid-cycle with 3 entries queued
        do_reset();
        ifa.en = 1'b1; ifa.trace_rdy = 1'b0;
        tick();
        drv_a(1'b1, 32'd12); tick();
        drv_a(1'b1, 32'd16); tick();
        drv_a(1'b1, 32'd20); tick();
        drv_a(1'b0, 32'd0);
        chk("t6_pre_head", ifa.trace_pc, 32'd12);
        chk("t6_pre_ret", ifa.retired_cnt, 32'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_state", ifa.state, 2'd0);
        chk("t6_cycle", ifa.cycle_cnt, 32'd0);
        chk("t6_retired", ifa.retired_cnt, 32'd0);
        chk("t6_tvld", ifa.trace_vld, 1'b0);
        chk("t6_tpc", ifa.trace_pc, 32'd0);
        tick();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
